cmp_share_arbiter: RTL and testbench



---
 rtl/cmp_share_pkg.sv | 22 ++
 rtl/cmp_share_arbiter_rr_pick.sv | 40 ++++
 rtl/eqcmp.sv | 12 +
 rtl/cmp_share_arbiter.sv | 100 ++++++++++
 tb/tb_cmp_share_arbiter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/cmp_share_pkg.sv
// Shared types and sizing helpers for the shared equality-comparator arbiter.
package cmp_share_pkg;

   localparam int DEFAULT_NREQ  = 4;
   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic {
      CMP_EQ = 1'b0,
      CMP_NE = 1'b1
   } cmp_op_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_e;

   // A single requester still needs a one-bit index so ports never collapse to zero width.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cmp_share_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping, via a doubled request vector.
module rr_pick
   import cmp_share_pkg::*;
#(
   parameter int NREQ = DEFAULT_NREQ,
   localparam int IDW = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  g,
   output logic            any
);

   logic [2*NREQ-1:0] dbl;
   int pos;

   assign dbl = {req, req};

   // Walk from the far end back toward ptr so the nearest hit is the one that sticks.
   always_comb begin
      grant = '0;
      g     = '0;
      any   = 1'b0;
      pos   = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (dbl[int'(ptr) + k]) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
               pos = pos - NREQ;
            end
            grant      = '0;
            grant[pos] = 1'b1;
            g          = IDW'(pos);
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eqcmp.sv
// Combinational equality comparator shared by all requesters.
module eqcmp #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq
);

   assign eq = (a == b);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Shares one eqcmp among NREQ requesters: round-robin grant, one registered operand stage,
// valid/ready on both sides, one compare per cycle with one cycle of latency.
module cmp_share_arbiter
   import cmp_share_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int NREQ  = DEFAULT_NREQ,
   localparam int IDW  = id_width(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]      req_ne,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic                 rsp_result
);

   arb_state_e       state;
   arb_state_e       state_next;
   logic             stage_valid;
   logic [WIDTH-1:0] stage_a;
   logic [WIDTH-1:0] stage_b;
   cmp_op_e          stage_ne;
   logic [IDW-1:0]   stage_id;
   logic [IDW-1:0]   ptr;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   g;
   logic             any;
   logic             can_accept;
   logic             accept;
   logic             eq;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .g     (g),
      .any   (any)
   );

   eqcmp #(.WIDTH(WIDTH)) u_eqcmp (
      .a  (stage_a),
      .b  (stage_b),
      .eq (eq)
   );

   // A draining response frees the stage in the same cycle, which keeps back-to-back throughput.
   assign can_accept = !stage_valid || rsp_ready;
   assign req_ready  = (any && can_accept && !reset) ? grant : '0;
   assign accept     = |req_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   state_next = accept ? FULL : EMPTY;
         FULL:    state_next = (accept || !rsp_ready) ? FULL : EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_comb begin
      stage_valid = (state == FULL);
   end

   // Operand stage and pointer only move on an accept, so stalls and unserved requests leave them alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_a  <= '0;
         stage_b  <= '0;
         stage_ne <= CMP_EQ;
         stage_id <= '0;
         ptr      <= '0;
      end else if (accept) begin
         stage_a  <= req_a[int'(g)*WIDTH +: WIDTH];
         stage_b  <= req_b[int'(g)*WIDTH +: WIDTH];
         stage_ne <= cmp_op_e'(req_ne[g]);
         stage_id <= g;
         ptr      <= (g == IDW'(NREQ - 1)) ? '0 : g + IDW'(1);
      end
   end

   // The cleared stage compares equal, so the result is qualified to read zero when idle.
   assign rsp_valid  = stage_valid;
   assign rsp_id     = stage_id;
   assign rsp_result = stage_valid && (eq ^ (stage_ne == CMP_NE));

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed self-checking bench for cmp_share_arbiter with NREQ=4, WIDTH=8.
module tb_cmp_share_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic                  clk;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_ne;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [1:0]            rsp_id;
   logic                  rsp_result;

   int checks = 0;
   int errors = 0;

   cmp_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ne     (req_ne),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] ne);
      req_valid = valid;
      req_ne    = ne;
   endtask

   task automatic setOps(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkRsp(input string tag, input logic v, input logic [1:0] id, input logic r);
      checkOutput({tag, " rsp_valid"},  32'(rsp_valid),  32'(v));
      checkOutput({tag, " rsp_id"},     32'(rsp_id),     32'(id));
      checkOutput({tag, " rsp_result"}, 32'(rsp_result), 32'(r));
   endtask

   logic [1:0] order_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic       order_res [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      reset     = 1'b1;
      rsp_ready = 1'b1;
      req_a     = '0;
      req_b     = '0;
      applyStimulus(4'b1111, 4'b0000);
      tick();
      tick();
      checkOutput("reset req_ready", 32'(req_ready), 32'h0);
      checkRsp("reset", 1'b0, 2'd0, 1'b0);

      reset = 1'b0;
      applyStimulus(4'b0000, 4'b0000);
      tick();

      $display("[TB] single request, equal operands");
      setOps(0, 8'h5A, 8'h5A);
      applyStimulus(4'b0001, 4'b0000);
      #1 checkOutput("single req_ready", 32'(req_ready), 32'h1);
      tick();
      applyStimulus(4'b0000, 4'b0000);
      checkRsp("single", 1'b1, 2'd0, 1'b1);

      $display("[TB] not-equal op on requester 2");
      setOps(2, 8'h01, 8'h80);
      applyStimulus(4'b0100, 4'b0100);
      #1 checkOutput("ne req_ready", 32'(req_ready), 32'h4);
      tick();
      checkRsp("ne differ", 1'b1, 2'd2, 1'b1);
      setOps(2, 8'h80, 8'h80);
      #1 checkOutput("ne2 req_ready", 32'(req_ready), 32'h4);
      tick();
      checkRsp("ne same", 1'b1, 2'd2, 1'b0);

      $display("[TB] pointer wrap after grant to 2");
      setOps(1, 8'h11, 8'h11);
      setOps(3, 8'h33, 8'h34);
      applyStimulus(4'b1010, 4'b0000);
      #1 checkOutput("wrap req_ready 3", 32'(req_ready), 32'h8);
      tick();
      checkRsp("wrap grant 3", 1'b1, 2'd3, 1'b0);
      applyStimulus(4'b0010, 4'b0000);
      #1 checkOutput("wrap req_ready 1", 32'(req_ready), 32'h2);
      tick();
      checkRsp("wrap grant 1", 1'b1, 2'd1, 1'b1);

      $display("[TB] reset with a pending response");
      applyStimulus(4'b0000, 4'b0000);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkRsp("mid reset", 1'b0, 2'd0, 1'b0);
      applyStimulus(4'b1001, 4'b0000);
      #1 checkOutput("post reset req_ready", 32'(req_ready), 32'h1);
      applyStimulus(4'b0000, 4'b0000);
      tick();
      checkRsp("post reset idle", 1'b0, 2'd0, 1'b0);

      $display("[TB] all requesters valid, back-to-back");
      for (int i = 0; i < NREQ; i++) begin
         setOps(i, 8'(i + 8'h40), 8'(i + 8'h40));
      end
      applyStimulus(4'b1111, 4'b0101);
      for (int k = 0; k < 5; k++) begin
         #1 checkOutput("rr req_ready", 32'(req_ready), 32'h1 << order_id[k]);
         tick();
         checkRsp("rr", 1'b1, order_id[k], order_res[k]);
      end

      $display("[TB] backpressure");
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 checkOutput("stall req_ready", 32'(req_ready), 32'h0);
         tick();
         checkRsp("stall", 1'b1, 2'd0, 1'b0);
      end
      rsp_ready = 1'b1;
      #1 checkOutput("release req_ready", 32'(req_ready), 32'h2);
      tick();
      checkRsp("release", 1'b1, 2'd1, 1'b1);
      applyStimulus(4'b0000, 4'b0000);
      tick();
      checkRsp("drain", 1'b0, 2'd1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
